// File: rtl/sb_spram256ka_pkg.sv
// Shared widths, access-mode enum and the control priority decode for the
// behavioural iCE40UP SPRAM model.
package spram_pkg;

    localparam int unsigned SPRAM_ADDR_WIDTH = 14;
    localparam int unsigned SPRAM_DATA_WIDTH = 16;
    localparam int unsigned SPRAM_DEPTH      = 16384;
    localparam int unsigned SPRAM_MASK_WIDTH = 4;

    typedef enum logic [2:0] {
        PWR_OFF,
        SLEEP,
        STANDBY,
        DESELECTED,
        READ,
        WRITE
    } spram_mode_e;

    // Power-off dominates sleep, sleep dominates standby, then chip select.
    // poweroff is active-low, like the primitive's POWEROFF pin.
    function automatic spram_mode_e spram_decode_mode(
        input logic poweroff,
        input logic sleep,
        input logic standby,
        input logic chipselect,
        input logic wren
    );
        spram_mode_e mode;
        if (!poweroff) begin
            mode = PWR_OFF;
        end else if (sleep) begin
            mode = SLEEP;
        end else if (standby) begin
            mode = STANDBY;
        end else if (!chipselect) begin
            mode = DESELECTED;
        end else if (wren) begin
            mode = WRITE;
        end else begin
            mode = READ;
        end
        return mode;
    endfunction

endpackage

// File: rtl/sb_spram256ka_if.sv
// Access bus of the SPRAM primitive; pin names follow the iCE40 cell so the
// framebuffer bank chain binds to it unchanged.
interface sb_spram256ka_if;
    import spram_pkg::*;

    logic [SPRAM_ADDR_WIDTH-1:0] address;
    logic [SPRAM_DATA_WIDTH-1:0] datain;
    logic [SPRAM_MASK_WIDTH-1:0] maskwren;
    logic                        wren;
    logic                        chipselect;
    logic                        standby;
    logic                        sleep;
    logic                        poweroff;
    logic [SPRAM_DATA_WIDTH-1:0] dataout;

    modport master (
        output address, datain, maskwren, wren, chipselect, standby, sleep, poweroff,
        input  dataout
    );

    modport slave (
        input  address, datain, maskwren, wren, chipselect, standby, sleep, poweroff,
        output dataout
    );

endinterface

// File: rtl/sb_spram256ka_nibble_bank.sv
// One 4-bit slice of the SPRAM array with its own write enable and a bulk
// clear used while the macro is powered off.
module spram_nibble_bank
    import spram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SPRAM_ADDR_WIDTH,
    parameter int unsigned DEPTH       = SPRAM_DEPTH,
    parameter logic [3:0]  INIT_NIBBLE = 4'h0
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            wr_nibble_i,
    output logic [3:0]            rd_nibble_c_o
);

    // Power-up contents mirror the primitive's defined initial state.
    logic [3:0] mem_q [DEPTH] = '{default: INIT_NIBBLE};

    // Clear wins over write so a power-off cycle never leaves stale data.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_WIDTH'(i)] <= INIT_NIBBLE;
            end
        end else if (wr_en_i) begin
            mem_q[addr_i] <= wr_nibble_i;
        end
    end

    assign rd_nibble_c_o = mem_q[addr_i];

endmodule

// File: rtl/sb_spram256ka.sv
// Behavioural iCE40UP SB_SPRAM256KA: 16K x 16 single-port RAM with nibble
// write mask, registered read data and standby/sleep/power-off controls.
module sb_spram256ka
    import spram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = SPRAM_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH = SPRAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    sb_spram256ka_if.slave  bus
);

    localparam int unsigned NIBBLES = DATA_WIDTH / 4;
    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;

    spram_mode_e           mode_c;
    logic [NIBBLES-1:0]    nib_we_c;
    logic                  clear_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] dataout_d;
    logic [DATA_WIDTH-1:0] dataout_q = '0;

    assign mode_c = spram_decode_mode(bus.poweroff, bus.sleep, bus.standby,
                                      bus.chipselect, bus.wren);

    // rst outranks every mode: it zeroes dataout and suppresses writes and clears.
    always_comb begin
        nib_we_c  = '0;
        clear_c   = 1'b0;
        dataout_d = dataout_q;
        if (rst) begin
            dataout_d = '0;
        end else begin
            case (mode_c)
                PWR_OFF: begin
                    clear_c   = 1'b1;
                    dataout_d = '0;
                end
                SLEEP:   dataout_d = '0;
                READ:    dataout_d = rd_word_c;
                WRITE:   nib_we_c  = bus.maskwren;
                default: dataout_d = dataout_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        dataout_q <= dataout_d;
    end

    assign bus.dataout = dataout_q;

    for (genvar g = 0; g < NIBBLES; g++) begin : g_bank
        spram_nibble_bank #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .DEPTH       (DEPTH),
            .INIT_NIBBLE (INIT_VALUE[4*g +: 4])
        ) u_bank (
            .clk           (clk),
            .wr_en_i       (nib_we_c[g]),
            .clear_i       (clear_c),
            .addr_i        (bus.address),
            .wr_nibble_i   (bus.datain[4*g +: 4]),
            .rd_nibble_c_o (rd_word_c[4*g +: 4])
        );
    end

endmodule

// File: tb/tb_sb_spram256ka.sv
// Directed scoreboard bench for sb_spram256ka: stimulus queues the dataout
// expected after each edge, a negedge monitor pops and compares.
module tb_sb_spram256ka;

    logic clk;
    logic rst;
    int unsigned cyc;

    sb_spram256ka_if bus ();

    sb_spram256ka dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors;
    int          checks;
    int unsigned due_q[$];
    logic [15:0] exp_q[$];
    string       tag_q[$];

    // Monitor: compare every expectation whose edge has just passed.
    always @(negedge clk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            checks++;
            if (due_q[0] < cyc) begin
                errors++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", tag_q[0], due_q[0], cyc);
            end else if (bus.dataout !== exp_q[0]) begin
                errors++;
                $display("FAIL %s: dataout=%h required=%h (cycle %0d)",
                         tag_q[0], bus.dataout, exp_q[0], cyc);
            end
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end
    end

    // One clock of stimulus; exp is the dataout required after the coming edge.
    task automatic step(input logic r, input logic po, input logic sl, input logic sb,
                        input logic cs, input logic we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m,
                        input logic [15:0] exp, input string tag);
        rst            = r;
        bus.poweroff   = po;
        bus.sleep      = sl;
        bus.standby    = sb;
        bus.chipselect = cs;
        bus.wren       = we;
        bus.address    = a;
        bus.datain     = d;
        bus.maskwren   = m;
        due_q.push_back(cyc + 1);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m,
                      input logic [15:0] hold, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a, d, m, hold, tag);
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a, 16'h0000, 4'h0, exp, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.poweroff = 1'b1;
        bus.sleep = 1'b0;
        bus.standby = 1'b0;
        bus.chipselect = 1'b0;
        bus.wren = 1'b0;
        bus.address = '0;
        bus.datain = '0;
        bus.maskwren = '0;

        #1;
        checks++;
        if (bus.dataout !== 16'h0000) begin
            errors++;
            $display("FAIL time_zero: dataout=%h required=0000", bus.dataout);
        end
        @(negedge clk);

        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 16'h0000, "reset");

        // Basic write then read, dataout frozen during writes.
        wr(14'h0123, 16'hA5C3, 4'hF, 16'h0000, "wr_hold0");
        rd(14'h0123, 16'hA5C3, "rd_0123");
        wr(14'h0200, 16'h7777, 4'hF, 16'hA5C3, "wr_hold_a5c3");
        rd(14'h0200, 16'h7777, "rd_0200");

        // Nibble mask at the top address.
        wr(14'h3FFF, 16'h0000, 4'hF, 16'h7777, "wr_3fff_clr");
        wr(14'h3FFF, 16'hFFFF, 4'b0101, 16'h7777, "wr_3fff_mask");
        rd(14'h3FFF, 16'h0F0F, "rd_mask_0101");
        wr(14'h3FFF, 16'h1234, 4'b0000, 16'h0F0F, "wr_mask_none");
        rd(14'h3FFF, 16'h0F0F, "rd_mask_none");

        // Standby: hold, and a write attempt is dropped.
        wr(14'h0050, 16'hBEEF, 4'hF, 16'h0F0F, "wr_beef");
        rd(14'h0050, 16'hBEEF, "rd_beef");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 14'h0050, 16'hDEAD, 4'hF, 16'hBEEF, "standby_hold");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0123, 16'h0, 4'h0, 16'hBEEF, "standby_no_read");
        rd(14'h0050, 16'hBEEF, "rd_after_standby");

        // Chip deselected: same behaviour.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0050, 16'hDEAD, 4'hF, 16'hBEEF, "desel_hold");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0123, 16'h0, 4'h0, 16'hBEEF, "desel_no_read");
        rd(14'h0050, 16'hBEEF, "rd_after_desel");

        // Sleep zeroes dataout, outranks standby, retains contents.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 14'h0050, 16'hDEAD, 4'hF, 16'h0000, "sleep_zero");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0050, 16'h0, 4'h0, 16'h0000, "sleep_over_standby");
        rd(14'h0050, 16'hBEEF, "rd_after_sleep");
        rd(14'h0123, 16'hA5C3, "rd_0123_after_sleep");

        // Reset clears dataout only and blocks a concurrent write.
        wr(14'h0010, 16'h1234, 4'hF, 16'hA5C3, "wr_1234");
        rd(14'h0010, 16'h1234, "rd_1234");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0010, 16'h5555, 4'hF, 16'h0000, "rst_with_write");
        rd(14'h0010, 16'h1234, "rd_after_rst");
        rd(14'h0123, 16'hA5C3, "rd_0123_after_rst");

        // Back-to-back writes then reads.
        for (int a = 0; a < 8; a++)
            wr(14'(a), 16'h1000 + 16'(a), 4'hF, 16'hA5C3, "b2b_wr_hold");
        for (int a = 0; a < 8; a++)
            rd(14'(a), 16'h1000 + 16'(a), "b2b_rd");

        // Power-off wipes the array back to the initial value.
        wr(14'h0000, 16'h1111, 4'hF, 16'h1007, "wr_1111");
        rd(14'h0000, 16'h1111, "rd_1111");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0000, 16'h2222, 4'hF, 16'h0000, "poweroff_zero");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0, 4'h0, 16'h0000, "power_back_hold");
        rd(14'h0000, 16'h0000, "rd_0000_wiped");
        rd(14'h0123, 16'h0000, "rd_0123_wiped");
        rd(14'h3FFF, 16'h0000, "rd_3fff_wiped");

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 4'h0, 16'h0000, "final_hold");

        repeat (3) @(negedge clk);
        while (due_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation never compared", tag_q[0]);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sb_spram256ka.md
Name: sb_spram256ka

Overview:
- Behavioural, synthesizable model of the iCE40UP single-port 256 Kbit SPRAM: 16,384 words x 16 bits.
- Provides a nibble write mask and low-power controls (standby, sleep, power-off).
- Used as the storage primitive under the framebuffer's 4-bank SPRAM chain, which decodes addr[15:14] to select one of four instances.
- Lets simulation and non-iCE40 targets run the framebuffer path unchanged.

Parameters:
- ADDR_WIDTH, 14, word address width. Depth is 2**ADDR_WIDTH = 16384.
- DATA_WIDTH, 16, word width. Fixed at 16 because the mask is 4 nibbles.
- INIT_VALUE, 16'h0000, contents of every word at time zero and after power-off.

Ports:
- clk  input  1  rising-edge clock (primitive CLOCK pin).
- rst  input  1  synchronous, active-high reset; clears dataout only.
- address  input  14  word address.
- datain  input  16  write data.
- maskwren  input  4  per-nibble write enable; bit i covers datain[4i+3:4i].
- wren  input  1  1 = write cycle, 0 = read cycle.
- chipselect  input  1  1 = access enabled.
- standby  input  1  1 = standby; no access, dataout held.
- sleep  input  1  1 = sleep; no access, dataout forced 0, contents retained.
- poweroff  input  1  ACTIVE-LOW. 1 = powered; 0 = off, contents lost.
- dataout  output  16  registered read data.

Behaviour:
- Reset is decided as: reset rst, synchronous, active-high; clock clk.
- Contents start at INIT_VALUE. rst never alters memory contents.
- All actions occur on the rising edge of clk. Evaluate in this priority order:
  1. rst=1: dataout <= 0. No write occurs even if requested.
  2. poweroff=0: every word <= INIT_VALUE (the clear may be done over multiple cycles, but reads must return INIT_VALUE once power returns); dataout <= 0; writes ignored.
  3. sleep=1: dataout <= 0; no access.
  4. standby=1: dataout holds its value; no access.
  5. chipselect=0: dataout holds; no access.
  6. chipselect=1, wren=0 (read): dataout <= mem[address]. Latency is 1 cycle: address presented before edge N, data valid after edge N.
  7. chipselect=1, wren=1 (write): for each i with maskwren[i]=1, mem[address] nibble i <= datain nibble i. Nibbles with mask 0 are unchanged. dataout holds its previous value (no write-through).
- Write with maskwren=4'b0000 changes nothing; dataout still holds.
- Read immediately after a write to the same address returns the new data: write at edge N, read address presented for edge N+1, data valid after N+1.
- Address is exactly 14 bits, so there is no out-of-range case.
- At time zero, dataout is 0.
- No X propagation on control inputs is required; treat them as 0/1.

Decomposition:
- Shared package spram_pkg:
  - localparams SPRAM_ADDR_WIDTH=14, SPRAM_DATA_WIDTH=16, SPRAM_DEPTH=16384, SPRAM_MASK_WIDTH=4.
  - Enum spram_mode_e {PWR_OFF, SLEEP, STANDBY, DESELECTED, READ, WRITE}, produced by a priority-decode function.
- One sub-module, spram_nibble_bank: a 16384 x 4 array with its own write enable.
  - Instantiate it 4 times, one per mask bit.
  - The top level holds the mode decode and the dataout register.

Test Plan:
- Write-read: write 16'hA5C3 at 14'h0123 with mask 4'hF; read 14'h0123 -> dataout = 16'hA5C3 one cycle after the read edge; dataout unchanged during the write cycle.
- Nibble mask: preload 16'h0000 at 14'h3FFF; write 16'hFFFF with mask 4'b0101 -> readback 16'h0F0F. Then write 16'h1234 with mask 4'b0000 -> still 16'h0F0F.
- Control gating: after reading 16'hBEEF, hold standby=1 for 3 cycles -> dataout stays 16'hBEEF and a write attempt is ignored. Repeat with chipselect=0 -> same result. Then sleep=1 -> dataout=0; after sleep=0, a read returns the original contents.
- Power-off: write 16'h1111 at 14'h0000; pulse poweroff=0 -> dataout=0; after power returns, a read of 14'h0000 -> 16'h0000 (INIT_VALUE).
- Reset: with dataout=16'h1234, assert rst together with a write of 16'h5555 to 14'h0010 -> next cycle dataout=0 and the word at 14'h0010 is unchanged. Release rst, read back a previously written word -> its contents are intact.
- Back-to-back: write addresses 0..7 with data 16'h1000+addr on consecutive cycles, then read 0..7 back to back -> each value appears exactly one cycle after its address.
